ps2_key_ctrl: RTL
=================

Name: ps2_key_ctrl

Overview:
- Scan-code sequencer between the PS/2 frame receiver and the keyboard consumer logic.
- Takes validated scan-code bytes (set 2) from the receiver and resolves E0 (extended) and F0 (break) prefixes through a state machine.
- Emits one make/break event per key action into a small FIFO with a valid/ready handshake.
- Tracks current key, held state and a press counter, and flags protocol, timeout and overflow errors.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 100000, idle clk cycles allowed in a prefix state before abort.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- byte_valid  in  1  one-cycle strobe: byte_data holds a parity/framing-checked scan byte
- byte_data  in  8  scan-code byte
- evt_valid  out  1  FIFO non-empty
- evt_ready  in  1  consumer accepts head event
- evt_code  out  8  head event scan code
- evt_ext  out  1  head event had E0 prefix
- evt_break  out  1  head event is a release
- cur_key  out  9  {ext,code} of last accepted make
- key_held  out  1  cur_key currently pressed
- press_count  out  8  accepted make events, wraps FF->00
- err_clr  in  1  clears sticky error flags
- proto_err  out  1  sticky: illegal prefix sequence
- timeout_err  out  1  sticky: prefix timeout
- ovf_err  out  1  sticky: event dropped, FIFO full

Behaviour:
- Reset (async assert, sync release on clk): FSM=IDLE, FIFO empty, timeout counter 0, all outputs 0.
- byte_valid is a one-cycle strobe; the block always accepts a byte, with no back-pressure to the receiver.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
- IDLE: E0->EXT; F0->BRK; other byte->emit make {ext=0}, stay IDLE.
- EXT: F0->EXT_BRK; E0->stay EXT (duplicate ignored); other->emit make {ext=1}, ->IDLE.
- BRK: other->emit break {ext=0}, ->IDLE; E0 or F0->proto_err=1, ->IDLE, no event.
- EXT_BRK: other->emit break {ext=1}, ->IDLE; E0 or F0->proto_err=1, ->IDLE, no event.
- Timeout counter:
  - Cleared in IDLE and on every byte_valid.
  - Increments each cycle in a prefix state.
  - On reaching TIMEOUT_CYCLES-1: ->IDLE, timeout_err=1, no event.
- Emit means push {code,ext,break} to the FIFO on the same edge the byte is sampled.
  - evt_valid rises the cycle after that edge (1-cycle latency).
- FIFO handshake:
  - Pop on an edge where evt_valid && evt_ready.
  - Head fields are stable while evt_valid=1 and not popped.
  - Push and pop in the same cycle when full: both succeed, occupancy unchanged, no overflow.
  - Push when full without pop: event dropped, ovf_err=1; side-band state still updates.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH; a separate count or extra pointer bit distinguishes full from empty.
- On make: cur_key<={ext,code}, key_held<=1, press_count<=press_count+1 (8-bit wrap).
- On break whose {ext,code}==cur_key: key_held<=0. Break of any other key leaves key_held unchanged.
- Errors are sticky until err_clr=1. If err_clr and a new error occur in the same cycle, the error wins (stays 1).
- Reset mid-sequence discards a pending prefix and all FIFO contents.

Optional Feature:
- PS2_TYPEMATIC_FILTER_EN defined: a make whose {ext,code}==cur_key while key_held=1 is treated as auto-repeat.
  - The event is not pushed, press_count does not change, and state returns to IDLE normally.
- Not defined: every make is pushed and counted, including auto-repeats.

Test Plan:
- Bytes 1C, F0, 1C with evt_ready=1 -> events {1C,ext0,make} then {1C,ext0,break}; press_count=1, key_held 1 then 0, cur_key=0_1C.
- Bytes E0 75, E0 F0 75 -> events {75,ext1,make}, {75,ext1,break}; no errors.
- Byte F0 then E0 -> proto_err=1, no event; err_clr pulse -> proto_err=0; next byte 1C gives make 1C.
- Byte E0 then no byte for TIMEOUT_CYCLES (bench overrides to 20) -> timeout_err=1 at cycle 20, FSM IDLE; next 2B gives make {2B,ext0}.
- evt_ready=0, push FIFO_DEPTH+1 makes -> FIFO_DEPTH events held, ovf_err=1, press_count=FIFO_DEPTH+1. Then push with evt_ready=1 while full -> no new overflow, order preserved.
- Bytes 1C,1C,1C, F0,1C -> with PS2_TYPEMATIC_FILTER_EN: 2 events, press_count=1. Without: 4 events, press_count=3.

Source files
------------

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: PS/2 set-2 scan-code sequencer.
// Resolves E0 (extended) and F0 (break) prefixes and queues one make/break
// event per key action in a small valid/ready FIFO. It also tracks the last
// pressed key, its held state and a press counter, and raises sticky
// protocol/timeout/overflow error flags.
// Optional build macro: PS2_TYPEMATIC_FILTER_EN. When it is defined,
// auto-repeat makes of the currently held key are suppressed.
module ps2_key_ctrl #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic [8:0] cur_key,
    output logic       key_held,
    output logic [7:0] press_count,
    input  logic       err_clr,
    output logic       proto_err,
    output logic       timeout_err,
    output logic       ovf_err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [8:0]    cur_key_q, cur_key_d;
    logic          key_held_q, key_held_d;
    logic [7:0]    press_q, press_d;
    logic          proto_err_q, proto_err_d;
    logic          tmo_err_q, tmo_err_d;
    logic          ovf_err_q, ovf_err_d;

    logic          emit, emit_ext, emit_brk;
    logic          proto_set, tmo_set, ovf_set;
    logic          make_ok, push_req, push_ok, pop, full, is_repeat;
    logic [8:0]    evt_key;

    // Prefix state machine and prefix-idle timeout counter.
    always_comb begin
        state_d   = state_q;
        tmo_d     = '0;
        emit      = 1'b0;
        emit_ext  = 1'b0;
        emit_brk  = 1'b0;
        proto_set = 1'b0;
        tmo_set   = 1'b0;
        if (byte_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (byte_data == 8'hE0)      state_d = S_EXT;
                    else if (byte_data == 8'hF0) state_d = S_BRK;
                    else                         emit = 1'b1;
                end
                S_EXT: begin
                    if (byte_data == 8'hF0) state_d = S_EXT_BRK;
                    else if (byte_data != 8'hE0) begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                S_BRK, S_EXT_BRK: begin
                    state_d = S_IDLE;
                    if (byte_data == 8'hE0 || byte_data == 8'hF0) begin
                        proto_set = 1'b1;
                    end else begin
                        emit     = 1'b1;
                        emit_brk = 1'b1;
                        emit_ext = (state_q == S_EXT_BRK);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_d = S_IDLE;
                tmo_set = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // Event filtering, FIFO bookkeeping, key tracking and sticky error flags.
    always_comb begin
        evt_key   = {emit_ext, byte_data};
        is_repeat = (evt_key == cur_key_q) && key_held_q;
`ifdef PS2_TYPEMATIC_FILTER_EN
        make_ok   = emit && !emit_brk && !is_repeat;
`else
        make_ok   = emit && !emit_brk;
`endif
        push_req  = make_ok || (emit && emit_brk);
        full      = (count_q == FULL_CNT);
        pop       = (count_q != '0) && evt_ready;
        push_ok   = push_req && (!full || pop);
        ovf_set   = push_req && full && !pop;

        wr_ptr_d  = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q;
        if (push_ok && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push_ok) count_d = count_q - 1'b1;

        cur_key_d  = cur_key_q;
        key_held_d = key_held_q;
        press_d    = press_q;
        if (make_ok) begin
            cur_key_d  = evt_key;
            key_held_d = 1'b1;
            press_d    = press_q + 8'd1;
        end else if (emit && emit_brk && (evt_key == cur_key_q)) begin
            key_held_d = 1'b0;
        end

        proto_err_d = proto_set | (proto_err_q & ~err_clr);
        tmo_err_d   = tmo_set   | (tmo_err_q   & ~err_clr);
        ovf_err_d   = ovf_set   | (ovf_err_q   & ~err_clr);
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            tmo_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cur_key_q   <= '0;
            key_held_q  <= 1'b0;
            press_q     <= '0;
            proto_err_q <= 1'b0;
            tmo_err_q   <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cur_key_q   <= cur_key_d;
            key_held_q  <= key_held_d;
            press_q     <= press_d;
            proto_err_q <= proto_err_d;
            tmo_err_q   <= tmo_err_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    // FIFO storage, cleared on reset so the head fields read 0 when empty.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= {byte_data, emit_ext, emit_brk};
        end
    end

    assign evt_valid   = (count_q != '0);
    assign evt_code    = mem_q[rd_ptr_q][9:2];
    assign evt_ext     = mem_q[rd_ptr_q][1];
    assign evt_break   = mem_q[rd_ptr_q][0];
    assign cur_key     = cur_key_q;
    assign key_held    = key_held_q;
    assign press_count = press_q;
    assign proto_err   = proto_err_q;
    assign timeout_err = tmo_err_q;
    assign ovf_err     = ovf_err_q;

endmodule
